// File: rtl/aes_enc_arbiter_if.sv
// Handshake bundle between the AES arbiter, its two requesters and the shared encipher core.
// The slave modport is the arbiter's view; master is the requester/core side.
interface aes_enc_arbiter_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_block0;
  logic [127:0] req_block1;
  logic [1:0]   req_keylen;

  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_block0;
  logic [127:0] rsp_block1;
  logic [1:0]   rsp_err;

  logic         core_next;
  logic         core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;

  logic         key_sel;
  logic         busy;

  modport slave (
    input  req_valid, req_block0, req_block1, req_keylen, rsp_ready, core_ready, core_result,
    output req_ready, rsp_valid, rsp_block0, rsp_block1, rsp_err, core_next, core_keylen,
           core_block, key_sel, busy
  );

  modport master (
    output req_valid, req_block0, req_block1, req_keylen, rsp_ready, core_ready, core_result,
    input  req_ready, rsp_valid, rsp_block0, rsp_block1, rsp_err, core_next, core_keylen,
           core_block, key_sel, busy
  );
endinterface

// File: rtl/aes_enc_arbiter.sv
// Round-robin arbiter sharing one AES encipher core between two requesters, with
// per-requester response registers and a watchdog that aborts a stalled operation.
module aes_enc_arbiter #(
  parameter int unsigned TIMEOUT = 31
) (
  input logic              clk,
  input logic              rst,
  aes_enc_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [5:0] TimeoutCnt = 6'(TIMEOUT);

  state_e             state_q, state_d;
  logic [5:0]         wdog_q, wdog_d;
  logic               last_grant_q, last_grant_d;
  logic               key_sel_q, key_sel_d;
  logic [127:0]       op_block_q, op_block_d;
  logic               op_keylen_q, op_keylen_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_err_q, rsp_err_d;
  logic [1:0][127:0]  rsp_block_q, rsp_block_d;

  logic [1:0]         eligible;
  logic [1:0]         grant;
  logic               grant_idx;

  // Eligibility uses the registered response flags, so a release this cycle only
  // makes the requester eligible on the next one.
  always_comb begin
    eligible  = bus.req_valid & ~rsp_valid_q;
    grant     = 2'b00;
    if (state_q == StIdle && !rst) begin
      if (eligible == 2'b11) begin
        grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
    grant_idx = grant[1];
  end

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    last_grant_d = last_grant_q;
    key_sel_d    = key_sel_q;
    op_block_d   = op_block_q;
    op_keylen_d  = op_keylen_q;
    rsp_err_d    = rsp_err_q;
    rsp_block_d  = rsp_block_q;
    rsp_valid_d  = rsp_valid_q & ~bus.rsp_ready;

    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          key_sel_d    = grant_idx;
          last_grant_d = grant_idx;
          op_block_d   = grant_idx ? bus.req_block1 : bus.req_block0;
          op_keylen_d  = bus.req_keylen[grant_idx];
          state_d      = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = 6'd0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.core_ready) begin
          rsp_block_d[key_sel_q] = bus.core_result;
          rsp_err_d[key_sel_q]   = 1'b0;
          state_d                = StDone;
        end else if (wdog_q == TimeoutCnt) begin
          rsp_block_d[key_sel_q] = '0;
          rsp_err_d[key_sel_q]   = 1'b1;
          state_d                = StDone;
        end else begin
          wdog_d = wdog_q + 6'd1;
        end
      end
      StDone: begin
        rsp_valid_d[key_sel_q] = 1'b1;
        state_d                = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wdog_q       <= 6'd0;
      last_grant_q <= 1'b1;
      key_sel_q    <= 1'b0;
      op_block_q   <= '0;
      op_keylen_q  <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 2'b00;
      rsp_block_q  <= '0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      last_grant_q <= last_grant_d;
      key_sel_q    <= key_sel_d;
      op_block_q   <= op_block_d;
      op_keylen_q  <= op_keylen_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_block_q  <= rsp_block_d;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_block0  = rsp_block_q[0];
  assign bus.rsp_block1  = rsp_block_q[1];
  assign bus.core_next   = (state_q == StIssue);
  assign bus.core_block  = op_block_q;
  assign bus.core_keylen = op_keylen_q;
  assign bus.key_sel     = key_sel_q;
  assign bus.busy        = (state_q != StIdle);

  a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q != StIdle) |-> (bus.req_ready == 2'b00));
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));

endmodule

// File: doc/aes_enc_arbiter.md
# aes_enc_arbiter

Round-robin arbiter that shares one AES encipher core between two requesters. It accepts a plaintext block and key length from each requester and issues one encryption at a time to the core, with a one-cycle `next` pulse. It holds `key_sel` stable so the key-schedule block supplies the granted requester's round keys. Each result goes into a per-requester response register with a valid/ready handshake. A watchdog aborts any operation whose core `ready` never arrives.

## Interface
- `TIMEOUT`, default 31: maximum cycles spent waiting for `core_ready` after `core_next`. Legal range is 16..63.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid[1:0]` in 2: requester i has a block to encrypt.
- `req_ready[1:0]` out 2: arbiter accepts requester i this cycle.
- `req_block0`, `req_block1` in 128 each: plaintext for requester 0 and 1.
- `req_keylen[1:0]` in 2: key length per requester (0 = AES-128, 1 = AES-256).
- `rsp_valid[1:0]` out 2: response register i is holding a result.
- `rsp_ready[1:0]` in 2: requester i consumes its response.
- `rsp_block0`, `rsp_block1` out 128 each: ciphertext for requester 0 and 1.
- `rsp_err[1:0]` out 2: response i was produced by a watchdog abort; its block is all zeros.
- `core_next` out 1: one-cycle start pulse to the encipher core.
- `core_keylen` out 1: key length for the current operation.
- `core_block` out 128: plaintext for the current operation.
- `core_ready` in 1: one-cycle completion pulse from the core.
- `core_result` in 128: core output, valid while `core_ready` = 1.
- `key_sel` out 1: index of the requester that owns the current or most recent grant.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **Eligibility:** requester i is eligible when `req_valid[i]`=1 and `rsp_valid[i]`=0, i.e. its response slot is empty.
- **IDLE, arbitration:**
  - If exactly one requester is eligible, grant it.
  - If both are eligible, grant the one that is not `last_grant`.
  - On a grant: `req_ready[grant]`=1 for that cycle, capture the block and keylen into `op_block`/`op_keylen`, set `key_sel`=`last_grant`=grant, then go to ISSUE.
- **ISSUE:** `core_next`=1 for exactly one cycle. Clear the watchdog counter to 0, then go to WAIT.
- **WAIT:**
  - If `core_ready`=1: capture `core_result` into `rsp_block[key_sel]`, with `rsp_err[key_sel]`=0. Go to DONE.
  - Else if counter = `TIMEOUT`: load `rsp_block[key_sel]`=0 and `rsp_err[key_sel]`=1. Go to DONE.
  - Otherwise increment the counter (6-bit, never wraps because `TIMEOUT` ≤ 63).
- **DONE:** set `rsp_valid[key_sel]`=1, then go to IDLE.
- **Response release:** `rsp_valid[i]` clears on a cycle where `rsp_valid[i]` & `rsp_ready[i]`. Each requester releases independently, in any FSM state.
- **Outputs to the core:** `core_block`=`op_block` and `core_keylen`=`op_keylen`, held constant from ISSUE until the next grant.
- **Stray `core_ready`** in IDLE, ISSUE or DONE is ignored.
- **`req_ready`** is never asserted outside IDLE, and never for an ineligible requester.

## Timing
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_block0`/`rsp_block1`=0.
  - `core_next`=0, `core_block`=0, `core_keylen`=0.
  - `key_sel`=0, `busy`=0.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- **Reset mid-operation:** state returns to IDLE and any pending response is discarded. A later `core_ready` is ignored.
- **Request acceptance** is combinational from `req_valid`/`rsp_valid` in IDLE. Accept at cycle T gives:
  - `core_next` at T+1;
  - WAIT from T+2;
  - if `core_ready` at cycle R, `rsp_valid` at R+2.
- **Watchdog:** with no `core_ready`, the abort decision falls at cycle T+2+`TIMEOUT` and `rsp_valid`/`rsp_err` are high at T+4+`TIMEOUT`.
- **Back-to-back:** the earliest next grant is the cycle after DONE. With continuous contention, grants alternate 0,1,0,1,…
- **Simultaneous release and re-request:** a `rsp_ready` handshake in IDLE makes that requester eligible only on the following cycle. Eligibility uses registered `rsp_valid`.

## Test plan
- **Single request:** reset, then `req_valid`=01 with block 0x00112233445566778899aabbccddeeff; core model returns 0x69c4e0d86a7b0430d8cdb78070b4c55a with `core_ready` 11 cycles after `core_next`. Required: `key_sel`=0, one `core_next` pulse, `rsp_valid[0]`=1 with that value, `rsp_err[0]`=0.
- **Tie-break and fairness:** `req_valid`=11 held for 4 operations. Required: grant order is 0,1,0,1 and `key_sel` matches each grant.
- **Backpressure:** requester 0 holds `rsp_ready[0]`=0 with `req_valid`=01 continuously. Required: after the first response, `req_ready[0]` stays 0 and the core stays idle. When requester 1 requests, it is granted.
- **Watchdog:** core model never asserts `core_ready` and `TIMEOUT`=31. Required: `rsp_valid`=1, `rsp_err`=1 and `rsp_block`=0 at T+35, then FSM back in IDLE.
- **Stray `core_ready`:** `core_ready` pulsed in IDLE and in ISSUE. Required: no response is written and no state change.
- **Reset mid-WAIT:** `rst`=1 for one cycle during WAIT, followed by a late `core_ready`. Required: all outputs at reset values, and no response is produced.
